fpdiv_arbiter: RTL

FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

---
 rtl/fpdiv_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fpdiv_arbiter.sv
// rtl/fpdiv_arbiter.sv - round-robin arbiter sharing one bfloat16 divider among N_REQ requesters
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid[N_REQ], req_x1/req_x2[16*N_REQ]  requester operands, slice i = [16i+15:16i]
//   req_ack[N_REQ]                             one-cycle accept pulse (ISSUE)
//   resp_valid[N_REQ], resp_y, resp_err        one-cycle result pulse (RESP), shared result bus
//   div_x1, div_x2, div_en                     operands and start pulse to the divider
//   div_y, div_ready                           divider result and ready
//   busy                                       high whenever the FSM is not IDLE

module fpdiv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_x1,
    input  logic [16*N_REQ-1:0]  req_x2,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [15:0]          resp_y,
    output logic                 resp_err,
    output logic [15:0]          div_x1,
    output logic [15:0]          div_x2,
    output logic                 div_en,
    input  logic [15:0]          div_y,
    input  logic                 div_ready,
    output logic                 busy
);
    localparam int          PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] QNAN     = 16'h7FC0;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;        // last requester served
    logic [PTR_W-1:0]   gnt;        // requester owning the current operation
    logic [PTR_W-1:0]   win;        // combinational round-robin winner
    logic [PTR_W:0]     rr_sum;
    logic               found;
    logic [7:0]         cnt;
    logic [15:0]        sel_x1;
    logic [15:0]        sel_x2;
    logic               ready_ok;
    logic               timed_out;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        found  = 1'b0;
        win    = ptr;
        rr_sum = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (rr_sum >= (PTR_W+1)'(N_REQ)) begin
                rr_sum = rr_sum - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_valid[rr_sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = rr_sum[PTR_W-1:0];
            end
        end
    end

    // Operand mux for the winner.
    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                sel_x1 = req_x1[16*i +: 16];
                sel_x2 = req_x2[16*i +: 16];
            end
        end
    end

    // The first WAIT cycle (cnt == 0) ignores div_ready: a level still high
    // from a previous operation must not be taken as this result.
    // ready_ok is checked before timed_out so a ready in the last cycle wins.
    assign ready_ok  = div_ready && (cnt != 8'd0);
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        div_en     = 1'b0;
        busy       = 1'b1;
        req_ack    = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                div_en = 1'b1;
                for (int i = 0; i < N_REQ; i++) begin
                    req_ack[i] = (gnt == PTR_W'(i));
                end
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ready_ok || timed_out) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                for (int i = 0; i < N_REQ; i++) begin
                    resp_valid[i] = (gnt == PTR_W'(i));
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are latched once at selection and held until the next
    // selection, so requester changes after selection are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= PTR_W'(N_REQ - 1);
            gnt      <= '0;
            cnt      <= '0;
            div_x1   <= '0;
            div_x2   <= '0;
            resp_y   <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= win;
                        div_x1 <= sel_x1;
                        div_x2 <= sel_x2;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (ready_ok) begin
                        resp_y   <= div_y;
                        resp_err <= 1'b0;
                    end else if (timed_out) begin
                        resp_y   <= QNAN;
                        resp_err <= 1'b1;
                    end
                end
                RESP: begin
                    ptr <= gnt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
